// File: rtl/icache_pkg.sv
// icache_pkg: shared defaults, FSM state and line record types for the instruction cache.
//   ICACHE_LINES / ICACHE_LINE_BYTES : default geometry
//   INST_LEN                         : instruction word width
//   icache_state_t                   : controller states {IDLE, REQ, WAIT}
//   icache_line_t                    : one line {valid, tag, data} at default geometry
package icache_pkg;
   localparam int ICACHE_LINES = 4;
   localparam int ICACHE_LINE_BYTES = 16;
   localparam int INST_LEN = 32;
   localparam int ICACHE_ADDR_W = 32;
   localparam int ICACHE_TAG_W = ICACHE_ADDR_W - $clog2(ICACHE_LINES) - $clog2(ICACHE_LINE_BYTES);
   typedef enum logic [1:0] {IDLE, REQ, WAIT} icache_state_t;
   typedef struct packed {
      logic valid;
      logic [ICACHE_TAG_W-1:0] tag;
      logic [8*ICACHE_LINE_BYTES-1:0] data;
   } icache_line_t;
endpackage

// File: rtl/icache_array.sv
// icache_array: valid/tag/data storage with combinational read and one write port.
//   clk, rst                      : clock, synchronous active-high reset (clears all valid bits)
//   rd_idx_i -> rd_valid_o/rd_tag_o/rd_data_o : combinational lookup
//   we_i, wr_idx_i, wr_valid_i, wr_tag_i, wr_data_i : line fill
//   clr_all_i                     : invalidate every line at the edge
module icache_array import icache_pkg::*; #(
   parameter int LINES = ICACHE_LINES,
   parameter int TAG_W = ICACHE_TAG_W,
   parameter int LINE_W = 8*ICACHE_LINE_BYTES,
   localparam int IDX_W = $clog2(LINES)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [IDX_W-1:0]  rd_idx_i,
   output logic              rd_valid_o,
   output logic [TAG_W-1:0]  rd_tag_o,
   output logic [LINE_W-1:0] rd_data_o,
   input  logic              we_i,
   input  logic [IDX_W-1:0]  wr_idx_i,
   input  logic              wr_valid_i,
   input  logic [TAG_W-1:0]  wr_tag_i,
   input  logic [LINE_W-1:0] wr_data_i,
   input  logic              clr_all_i
);
   logic [LINES-1:0] valid_q, valid_d;
   logic [TAG_W-1:0] tag_q [LINES];
   logic [LINE_W-1:0] data_q [LINES];
   // a fill written during a clear carries wr_valid_i=0, so the clear is never undone
   always_comb begin
      valid_d = clr_all_i ? '0 : valid_q;
      if (we_i) valid_d[wr_idx_i] = wr_valid_i;
   end
   always_ff @(posedge clk) begin
      if (rst) valid_q <= '0;
      else valid_q <= valid_d;
   end
   always_ff @(posedge clk) begin
      if (we_i) begin
         tag_q[wr_idx_i] <= wr_tag_i;
         data_q[wr_idx_i] <= wr_data_i;
      end
   end
   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_tag_o = tag_q[rd_idx_i];
   assign rd_data_o = data_q[rd_idx_i];
endmodule

// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped read-only instruction cache with single-line fill FSM.
//   fetch side : req_valid, req_addr, flush in; rsp_valid, rsp_inst, stall_out out (combinational)
//   memory side: mem_req_valid/mem_req_addr out with mem_req_ready in; mem_rsp_valid/mem_rsp_line in
//   ICACHE_PERF_CNT_EN defined: adds hit_cnt / miss_cnt outputs
module icache_ctrl import icache_pkg::*; #(
   parameter int ADDR_W = 32,
   parameter int LINES = ICACHE_LINES,
   parameter int LINE_BYTES = ICACHE_LINE_BYTES
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   input  logic [ADDR_W-1:0]       req_addr,
   input  logic                    flush,
   output logic                    rsp_valid,
   output logic [INST_LEN-1:0]     rsp_inst,
   output logic                    stall_out,
   output logic                    mem_req_valid,
   output logic [ADDR_W-1:0]       mem_req_addr,
   input  logic                    mem_req_ready,
   input  logic                    mem_rsp_valid,
   input  logic [8*LINE_BYTES-1:0] mem_rsp_line
`ifdef ICACHE_PERF_CNT_EN
   ,
   output logic [31:0]             hit_cnt,
   output logic [31:0]             miss_cnt
`endif
);
   localparam int OFF = $clog2(LINE_BYTES);
   localparam int IDX = $clog2(LINES);
   localparam int TAG_W = ADDR_W - IDX - OFF;
   icache_state_t state_q;
   logic mem_req_valid_q, flush_pend_q;
   logic [ADDR_W-OFF-1:0] line_q;
   logic rd_valid, hit, lookup, miss, fill, drop;
   logic [TAG_W-1:0] rd_tag;
   logic [8*LINE_BYTES-1:0] rd_data;
   logic unused_ok;
   assign unused_ok = ^req_addr[1:0];
   assign hit = rd_valid && rd_tag == req_addr[ADDR_W-1:OFF+IDX];
   assign lookup = state_q == IDLE && req_valid;
   assign miss = lookup && !hit;
   assign fill = state_q == WAIT && mem_rsp_valid;
   // a flush seen at any point of the fill, including its final edge, discards the line
   assign drop = flush_pend_q || flush;
   assign rsp_valid = !rst && lookup && hit;
   assign stall_out = !rst && (state_q != IDLE || miss);
   assign rsp_inst = rd_data[req_addr[OFF-1:2]*INST_LEN +: INST_LEN];
   assign mem_req_valid = mem_req_valid_q;
   assign mem_req_addr = {line_q, {OFF{1'b0}}};
   icache_array #(.LINES(LINES), .TAG_W(TAG_W), .LINE_W(8*LINE_BYTES)) u_array (
      .clk        (clk),
      .rst        (rst),
      .rd_idx_i   (req_addr[OFF+IDX-1:OFF]),
      .rd_valid_o (rd_valid),
      .rd_tag_o   (rd_tag),
      .rd_data_o  (rd_data),
      .we_i       (fill),
      .wr_idx_i   (line_q[IDX-1:0]),
      .wr_valid_i (!drop),
      .wr_tag_i   (line_q[ADDR_W-OFF-1:IDX]),
      .wr_data_i  (mem_rsp_line),
      .clr_all_i  ((state_q == IDLE && flush) || (fill && drop))
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         mem_req_valid_q <= 1'b0;
         flush_pend_q <= 1'b0;
         line_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (miss) begin
               state_q <= REQ;
               mem_req_valid_q <= 1'b1;
               line_q <= req_addr[ADDR_W-1:OFF];
            end
            REQ: begin
               flush_pend_q <= drop;
               if (mem_req_ready) begin
                  state_q <= WAIT;
                  mem_req_valid_q <= 1'b0;
               end
            end
            WAIT: begin
               flush_pend_q <= drop && !mem_rsp_valid;
               if (mem_rsp_valid) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
`ifdef ICACHE_PERF_CNT_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt_q <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q <= hit_cnt_q + 32'(rsp_valid);
         miss_cnt_q <= miss_cnt_q + 32'(miss);
      end
   end
   assign hit_cnt = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: self-checking bench for icache_ctrl (directed table, corner sequences, random vs model).
module tb_icache_ctrl;
   import icache_pkg::*;
   logic clk = 0, rst = 1, req_valid = 0, flush = 0, mem_req_ready = 0, mem_rsp_valid = 0;
   logic [31:0] req_addr = 0;
   logic [127:0] mem_rsp_line = 0;
   logic rsp_valid, stall_out, mem_req_valid;
   logic [31:0] rsp_inst, mem_req_addr;
`ifdef ICACHE_PERF_CNT_EN
   logic [31:0] hit_cnt, miss_cnt;
`endif
   always #5 clk = ~clk;
   icache_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_addr      (req_addr),
      .flush         (flush),
      .rsp_valid     (rsp_valid),
      .rsp_inst      (rsp_inst),
      .stall_out     (stall_out),
      .mem_req_valid (mem_req_valid),
      .mem_req_addr  (mem_req_addr),
      .mem_req_ready (mem_req_ready),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_line  (mem_rsp_line)
`ifdef ICACHE_PERF_CNT_EN
      ,
      .hit_cnt       (hit_cnt),
      .miss_cnt      (miss_cnt)
`endif
   );
   int n_checks = 0, n_fail = 0;
   // memory responder
   bit pending = 0, spur_en = 0, rnd_cfg = 0;
   int lat_cnt = 0, wait_cnt = 0, cfg_ready_delay = 0, cfg_rsp_lat = 1, acc_cnt = 0;
   logic [31:0] acc_addr = 0;
   // reference model: cache contents plus the one fill in flight
   bit m_valid [4];
   logic [31:0] m_tag [4];
   logic [127:0] m_line [4];
   bit m_busy, m_await, m_flush_seen;
   logic [31:0] m_fill_addr;
   int m_hits, m_misses;
   logic s_rsp_valid, s_stall, s_mem_req_valid;
   logic [31:0] s_inst, s_mem_req_addr;
   typedef struct {logic [31:0] addr; bit hit;} vec_t;
   vec_t tbl [12];

   function automatic logic [127:0] line_of(input logic [31:0] a);
      logic [127:0] l;
      logic [31:0] b;
      b = a & ~32'hF;
      for (int w = 0; w < 4; w++) l[w*32 +: 32] = b * 32'h9E37_79B9 + w * 32'h0101_0101 + 32'h1357_9BDF;
      return l;
   endfunction

   function automatic logic [31:0] word_of(input logic [31:0] a);
      logic [127:0] l;
      l = line_of(a);
      return l[((a >> 2) % 4) * 32 +: 32];
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      foreach (m_valid[i]) m_valid[i] = 0;
      m_busy = 0; m_await = 0; m_flush_seen = 0; m_hits = 0; m_misses = 0;
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: no response within bound", name);
   endtask

   // one clock cycle: fetch inputs already driven by the caller
   task automatic cyc();
      int idx, wd;
      bit hit;
      logic [31:0] tg;
      mem_rsp_valid = 0;
      mem_rsp_line = {4{$urandom()}};
      mem_req_ready = 0;
      if (!rst) begin
         if (pending) lat_cnt--;
         mem_rsp_valid = pending && lat_cnt == 0;
         if (mem_rsp_valid) mem_rsp_line = line_of(acc_addr);
         else if (!pending && spur_en && $urandom_range(0, 99) < 3) mem_rsp_valid = 1;
         mem_req_ready = mem_req_valid && wait_cnt >= cfg_ready_delay;
      end
      #1;
      s_rsp_valid = rsp_valid; s_stall = stall_out; s_inst = rsp_inst;
      s_mem_req_valid = mem_req_valid; s_mem_req_addr = mem_req_addr;
      idx = (req_addr >> 4) % 4; tg = req_addr >> 6; wd = (req_addr >> 2) % 4;
      hit = m_valid[idx] && m_tag[idx] == tg;
      if (rst) begin
         chk("rst_rsp_valid", s_rsp_valid, 0);
         chk("rst_stall", s_stall, 0);
      end else if (!m_busy) begin
         chk("rsp_valid", s_rsp_valid, req_valid && hit);
         chk("stall", s_stall, req_valid && !hit);
         chk("mem_req_valid_idle", s_mem_req_valid, 0);
         if (req_valid && hit) chk("rsp_inst", s_inst, m_line[idx][wd*32 +: 32]);
      end else begin
         chk("busy_rsp_valid", s_rsp_valid, 0);
         chk("busy_stall", s_stall, 1);
         chk("mem_req_valid", s_mem_req_valid, m_await);
         if (m_await) chk("mem_req_addr", s_mem_req_addr, m_fill_addr);
      end
      if (rst) model_reset();
      else if (!m_busy) begin
         if (req_valid && hit) m_hits++;
         if (flush) foreach (m_valid[i]) m_valid[i] = 0;
         if (req_valid && !hit) begin
            m_busy = 1; m_await = 1; m_fill_addr = req_addr & ~32'hF; m_misses++;
         end
      end else begin
         if (flush) m_flush_seen = 1;
         if (m_await) begin
            if (mem_req_ready) m_await = 0;
         end else if (mem_rsp_valid) begin
            idx = (m_fill_addr >> 4) % 4;
            m_line[idx] = line_of(m_fill_addr);
            m_tag[idx] = m_fill_addr >> 6;
            if (m_flush_seen) foreach (m_valid[i]) m_valid[i] = 0;
            m_valid[idx] = !m_flush_seen;
            m_busy = 0; m_flush_seen = 0;
         end
      end
      if (rst) begin
         pending = 0; wait_cnt = 0;
      end else begin
         if (mem_rsp_valid && pending) pending = 0;
         if (mem_req_valid && mem_req_ready) begin
            pending = 1; lat_cnt = cfg_rsp_lat; acc_cnt++; acc_addr = mem_req_addr; wait_cnt = 0;
         end else if (mem_req_valid) wait_cnt++;
      end
      if (rnd_cfg && !pending && !mem_req_valid) begin
         cfg_ready_delay = $urandom_range(0, 3);
         cfg_rsp_lat = $urandom_range(1, 3);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic access(input logic [31:0] a, output int stalls);
      int n;
      n = 0; stalls = 0;
      req_valid = 1; req_addr = a;
      cyc();
      while (!s_rsp_valid && n < 40) begin
         stalls++; n++;
         cyc();
      end
      if (!s_rsp_valid) timeout("access");
      req_valid = 0;
   endtask

   task automatic finish_fill();
      int n;
      n = 0;
      while (!s_rsp_valid && n < 40) begin
         n++;
         cyc();
      end
      if (!s_rsp_valid) timeout("finish_fill");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int st, a0;
      logic [31:0] conf [3];
      tbl[0] = '{32'h000, 1}; tbl[1] = '{32'h00C, 1}; tbl[2] = '{32'h214, 1}; tbl[3] = '{32'h21C, 1};
      tbl[4] = '{32'h100, 0}; tbl[5] = '{32'h104, 1}; tbl[6] = '{32'h000, 0}; tbl[7] = '{32'h030, 0};
      tbl[8] = '{32'h03C, 1}; tbl[9] = '{32'h110, 0}; tbl[10] = '{32'h218, 0}; tbl[11] = '{32'h008, 1};
      conf[0] = 32'h000; conf[1] = 32'h040; conf[2] = 32'h000;
      model_reset();
      @(posedge clk);
      #1;
      // reset, with fetch requesting
      for (int i = 0; i < 3; i++) begin
         req_valid = i[0]; req_addr = 32'h104;
         cyc();
      end
      rst = 0; req_valid = 0;
      cyc();
      chk("reset_stall", s_stall, 0);
      chk("reset_mem_req_valid", s_mem_req_valid, 0);
`ifdef ICACHE_PERF_CNT_EN
      chk("reset_hit_cnt", hit_cnt, 0);
      chk("reset_miss_cnt", miss_cnt, 0);
`endif
      // cold miss
      a0 = acc_cnt;
      access(32'h104, st);
      chk("cold_stalls", st, 3);
      chk("cold_reqs", acc_cnt - a0, 1);
      chk("cold_req_addr", acc_addr, 32'h100);
      chk("cold_inst", s_inst, word_of(32'h104));
      // hit
      req_valid = 1; req_addr = 32'h108;
      cyc();
      chk("hit_rsp_valid", s_rsp_valid, 1);
      chk("hit_stall", s_stall, 0);
      chk("hit_mem_req_valid", s_mem_req_valid, 0);
      chk("hit_inst", s_inst, word_of(32'h108));
      req_valid = 0;
      cyc();
      chk("hit_no_req", s_mem_req_valid, 0);
      // conflict misses on index 0
      for (int i = 0; i < 3; i++) begin
         a0 = acc_cnt;
         access(conf[i], st);
         chk("conf_stalls", st, 3);
         chk("conf_reqs", acc_cnt - a0, 1);
         chk("conf_req_addr", acc_addr, conf[i]);
         chk("conf_inst", s_inst, word_of(conf[i]));
      end
      // backpressure: ready low for 3 REQ cycles
      cfg_ready_delay = 3;
      a0 = acc_cnt;
      req_valid = 1; req_addr = 32'h214;
      cyc();
      chk("bp_miss_stall", s_stall, 1);
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("bp_valid", s_mem_req_valid, 1);
         chk("bp_addr", s_mem_req_addr, 32'h210);
         chk("bp_stall", s_stall, 1);
      end
      cyc();
      chk("bp_wait_stall", s_stall, 1);
      chk("bp_wait_novalid", s_mem_req_valid, 0);
      cyc();
      chk("bp_hit", s_rsp_valid, 1);
      chk("bp_reqs", acc_cnt - a0, 1);
      req_valid = 0;
      cfg_ready_delay = 0;
      // directed lookup table
      for (int i = 0; i < 12; i++) begin
         req_valid = 1; req_addr = tbl[i].addr;
         cyc();
         chk("tbl_rsp_valid", s_rsp_valid, tbl[i].hit);
         chk("tbl_stall", s_stall, !tbl[i].hit);
         if (!tbl[i].hit) finish_fill();
         req_valid = 0;
      end
      // flush during WAIT forces a second fill of the same line
      cfg_rsp_lat = 3;
      a0 = acc_cnt;
      req_valid = 1; req_addr = 32'h328;
      cyc();
      cyc();
      flush = 1;
      cyc();
      flush = 0;
      chk("fw_wait_stall", s_stall, 1);
      chk("fw_wait_novalid", s_mem_req_valid, 0);
      finish_fill();
      chk("fw_reqs", acc_cnt - a0, 2);
      chk("fw_req_addr", acc_addr, 32'h320);
      // flush in IDLE: same-cycle hit served, then the line is gone
      flush = 1;
      cyc();
      flush = 0;
      chk("fi_hit", s_rsp_valid, 1);
      cyc();
      chk("fi_after_stall", s_stall, 1);
      finish_fill();
      req_valid = 0;
      // reset in WAIT abandons the fill
      req_valid = 1; req_addr = 32'h404;
      cyc();
      cyc();
      cyc();
      chk("rw_in_wait", s_stall, 1);
      rst = 1;
      cyc();
      rst = 0;
`ifdef ICACHE_PERF_CNT_EN
      chk("rw_hit_cnt", hit_cnt, 0);
      chk("rw_miss_cnt", miss_cnt, 0);
`endif
      cyc();
      chk("rw_relookup_miss", s_stall, 1);
      chk("rw_relookup_rsp", s_rsp_valid, 0);
      cyc();
      chk("rw_new_req", s_mem_req_valid, 1);
      finish_fill();
      req_valid = 0;
      // randomized traffic against the model
      rnd_cfg = 1; spur_en = 1;
      for (int i = 0; i < 3000; i++) begin
         rst = $urandom_range(0, 199) == 0;
         req_valid = $urandom_range(0, 9) < 8;
         req_addr = $urandom_range(0, 255);
         flush = $urandom_range(0, 19) == 0;
         cyc();
      end
      rst = 0; req_valid = 0; flush = 0; spur_en = 0;
      cyc();
`ifdef ICACHE_PERF_CNT_EN
      chk("rnd_hit_cnt", hit_cnt, m_hits);
      chk("rnd_miss_cnt", miss_cnt, m_misses);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
